// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: issue-stage hazard tracker for multi-cycle functional units.
// In-flight writes are held in a writeback reservation shift register. The
// block arbitrates the single register-file write port, raises the issue
// stall, flags writeback-stage bypass hits and strobes the writeback.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   issue_valid/flush   operation presented / squashed this cycle
//   issue_wen/rd/lat    destination write enable, register, latency
//   use_rs1/2, rs1/2    source operand usage and indices
//   stall               operation not accepted this cycle
//   fwd1, fwd2          source supplied by the writeback bypass
//   wb_valid, wb_rd     registered writeback strobe and register
//   busy                per-register pending-write mask
module fpu_scoreboard #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned MAXLAT = 8,
  parameter int unsigned LW     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_flush,
  input  logic            issue_wen,
  input  logic [AW-1:0]   issue_rd,
  input  logic [LW-1:0]   issue_lat,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            stall,
  output logic            fwd1,
  output logic            fwd2,
  output logic            wb_valid,
  output logic [AW-1:0]   wb_rd,
  output logic [NREG-1:0] busy
);

  localparam int NSLOT = int'(MAXLAT);
  localparam int NR    = int'(NREG);

  logic [MAXLAT-1:0] slot_v_q, slot_v_d;
  logic [AW-1:0]     slot_rd_q [MAXLAT];
  logic [AW-1:0]     slot_rd_d [MAXLAT];

  logic [LW-1:0] lat_eff;
  logic          wr_op, rs1_nz, rs2_nz;
  logic          raw1, raw2, hit1_wb, hit2_wb, waw, port;
  logic          hazard, accept;

  // Clamp requested latency into 1..MAXLAT
  always_comb begin
    lat_eff = issue_lat;
    if (issue_lat == '0) begin
      lat_eff = LW'(1);
    end else if (issue_lat > LW'(MAXLAT)) begin
      lat_eff = LW'(MAXLAT);
    end
  end

  // Hazard detection against the reservation slots
  always_comb begin
    wr_op   = issue_wen && (issue_rd != '0);
    rs1_nz  = use_rs1 && (rs1 != '0);
    rs2_nz  = use_rs2 && (rs2 != '0);
    raw1    = 1'b0;
    raw2    = 1'b0;
    hit1_wb = 1'b0;
    hit2_wb = 1'b0;
    waw     = 1'b0;
    port    = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (slot_v_q[i]) begin
        if (i == 0) begin
          hit1_wb = (slot_rd_q[i] == rs1);
          hit2_wb = (slot_rd_q[i] == rs2);
        end else begin
          if (slot_rd_q[i] == rs1) raw1 = 1'b1;
          if (slot_rd_q[i] == rs2) raw2 = 1'b1;
        end
        // an older write landing at or after ours would clobber the result
        if (i >= int'(lat_eff) && slot_rd_q[i] == issue_rd) waw = 1'b1;
        // slot[L] shifts into slot[L-1], the one we would claim
        if (i == int'(lat_eff)) port = 1'b1;
      end
    end
    hazard = (rs1_nz && raw1) || (rs2_nz && raw2) || (wr_op && (waw || port));
    stall  = issue_valid && !issue_flush && hazard;
    accept = issue_valid && !issue_flush && !hazard;
    fwd1   = issue_valid && rs1_nz && hit1_wb && !raw1;
    fwd2   = issue_valid && rs2_nz && hit2_wb && !raw2;
  end

  // Shift toward writeback; an accepted write claims slot[L-1]
  always_comb begin
    slot_v_d = '0;
    for (int i = 0; i < NSLOT; i++) begin
      slot_rd_d[i] = '0;
    end
    for (int i = 0; i < NSLOT - 1; i++) begin
      slot_v_d[i]  = slot_v_q[i+1];
      slot_rd_d[i] = slot_rd_q[i+1];
    end
    if (accept && wr_op) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (i == int'(lat_eff) - 1) begin
          slot_v_d[i]  = 1'b1;
          slot_rd_d[i] = issue_rd;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_v_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        slot_rd_q[i] <= '0;
      end
    end else begin
      slot_v_q <= slot_v_d;
      for (int i = 0; i < NSLOT; i++) begin
        slot_rd_q[i] <= slot_rd_d[i];
      end
    end
  end

  // Pending-write mask; register 0 never has a reservation
  always_comb begin
    busy = '0;
    for (int r = 1; r < NR; r++) begin
      for (int i = 0; i < NSLOT; i++) begin
        if (slot_v_q[i] && slot_rd_q[i] == AW'(r)) busy[r] = 1'b1;
      end
    end
  end

  assign wb_valid = slot_v_q[0];
  assign wb_rd    = slot_rd_q[0];

endmodule
